// File: rtl/pcie_led_pkg.sv
// Shared types, control-word field positions and the status-word format
// for the host-programmable LED controller.
package pcie_led_pkg;

    typedef enum logic [1:0] {
        LED_CNT    = 2'd0,
        LED_STATIC = 2'd1,
        LED_PWM    = 2'd2,
        LED_BLINK  = 2'd3
    } led_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CAP,
        ST_WR
    } poll_state_e;

    localparam int HOST_EN_BIT = 63;
    localparam int MODE_HI     = 62;
    localparam int MODE_LO     = 61;
    localparam int RATE_HI     = 44;
    localparam int RATE_LO     = 40;
    localparam int DUTY_HI     = 39;
    localparam int DUTY_LO     = 32;

    localparam logic [7:0] STATUS_SIG = 8'hA5;

    // Heartbeat word: signature, echoed enable/mode bits, and the poll number
    function automatic logic [63:0] status_word(input logic [63:0] ctrl,
                                               input logic [31:0] count);
        status_word = {STATUS_SIG, 8'h00, ctrl[HOST_EN_BIT -: 3], 5'b0, 8'h00, count};
    endfunction

endpackage

// File: rtl/led_mode_gen.sv
// LED output stage: decodes the captured control word into one of four
// drive modes and registers the result.
module led_mode_gen
    import pcie_led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CNT_W    = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         ctrl_reg,
    input  logic                ctrl_valid,
    input  logic [CNT_W-1:0]    cnt,
    input  logic [7:0]          pwm_cnt,
    output logic [NUM_LEDS-1:0] led
);

    logic [NUM_LEDS-1:0] led_d, led_q;
    logic [NUM_LEDS-1:0] pattern;
    logic [7:0]          duty;
    logic [31:0]         blink_sh;
    logic [CNT_W-1:0]    cnt_sh;
    led_mode_e           mode_eff;
    logic                unused_ctrl;

    assign unused_ctrl = ^ctrl_reg;

    always_comb begin
        pattern  = ctrl_reg[NUM_LEDS-1:0];
        duty     = ctrl_reg[DUTY_HI:DUTY_LO];
        mode_eff = led_mode_e'(ctrl_reg[MODE_HI:MODE_LO]);
        // Counter mode until the host has a valid word and has opted in
        if (!ctrl_valid || !ctrl_reg[HOST_EN_BIT]) begin
            mode_eff = LED_CNT;
        end
        blink_sh = 32'd16 + 32'(ctrl_reg[RATE_HI:RATE_LO]);
        if (blink_sh > 32'(CNT_W - 1)) begin
            blink_sh = 32'(CNT_W - 1);
        end
        cnt_sh = cnt >> blink_sh;
        case (mode_eff)
            LED_STATIC: led_d = pattern;
            LED_PWM:    led_d = (pwm_cnt < duty) ? pattern : '0;
            LED_BLINK:  led_d = cnt_sh[0] ? pattern : '0;
            default:    led_d = cnt[CNT_W-1 -: NUM_LEDS];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/pcie_led_ctrl.sv
// Polls a control word from shared RAM every POLL_DIV cycles, drives the
// LEDs from it, and writes a heartbeat/status word back after each poll.
module pcie_led_ctrl
    import pcie_led_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int RAM_ADDR_W = 9,
    parameter int CTRL_ADDR  = 0,
    parameter int POLL_DIV   = 1024,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [RAM_ADDR_W-1:0] ram_address,
    output logic                  ram_chipselect,
    output logic                  ram_clken,
    output logic                  ram_write,
    output logic [63:0]           ram_writedata,
    output logic [7:0]            ram_byteenable,
    input  logic [63:0]           ram_readdata,
    output logic [NUM_LEDS-1:0]   led,
    output logic                  ctrl_valid,
    output logic [31:0]           poll_count
);

    localparam int TMR_W = $clog2(POLL_DIV);
    localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(POLL_DIV - 1);
    localparam logic [1:0]            WAIT_LAST = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [RAM_ADDR_W-1:0] RD_ADDR   = RAM_ADDR_W'(CTRL_ADDR);
    localparam logic [RAM_ADDR_W-1:0] WR_ADDR   = RAM_ADDR_W'(CTRL_ADDR + 1);

    poll_state_e       state_q, state_d;
    logic [TMR_W-1:0]  poll_tmr_q, poll_tmr_d;
    logic [1:0]        wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic [63:0]       ctrl_reg_q, ctrl_reg_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic [31:0]       poll_count_q, poll_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            poll_tmr_q   <= '0;
            wait_q       <= '0;
            cnt_q        <= '0;
            pwm_cnt_q    <= '0;
            ctrl_reg_q   <= '0;
            ctrl_valid_q <= 1'b0;
            poll_count_q <= '0;
        end else begin
            state_q      <= state_d;
            poll_tmr_q   <= poll_tmr_d;
            wait_q       <= wait_d;
            cnt_q        <= cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            ctrl_reg_q   <= ctrl_reg_d;
            ctrl_valid_q <= ctrl_valid_d;
            poll_count_q <= poll_count_d;
        end
    end

    // The poll timer free-runs through every state so poll starts stay periodic
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        poll_tmr_d = poll_tmr_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (poll_tmr_q == TMR_LAST) begin
                    poll_tmr_d = '0;
                    state_d    = ST_RD;
                end
            end
            ST_RD: begin
                wait_d  = '0;
                state_d = (RD_LATENCY == 1) ? ST_CAP : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_CAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_CAP:  state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        pwm_cnt_d    = pwm_cnt_q + 1'b1;
        ctrl_reg_d   = ctrl_reg_q;
        ctrl_valid_d = ctrl_valid_q;
        poll_count_d = poll_count_q;
        if (state_q == ST_CAP) begin
            ctrl_reg_d   = ram_readdata;
            ctrl_valid_d = 1'b1;
        end
        if (state_q == ST_WR) begin
            poll_count_d = poll_count_q + 32'd1;
        end
    end

    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = RD_ADDR;
        ram_writedata  = '0;
        case (state_q)
            ST_RD: ram_chipselect = 1'b1;
            ST_WR: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = WR_ADDR;
                ram_writedata  = status_word(ctrl_reg_q, poll_count_q + 32'd1);
            end
            default: ;
        endcase
    end

    assign ram_clken      = 1'b1;
    assign ram_byteenable = 8'hFF;
    assign ctrl_valid     = ctrl_valid_q;
    assign poll_count     = poll_count_q;

    led_mode_gen #(
        .NUM_LEDS(NUM_LEDS),
        .CNT_W   (CNT_W)
    ) u_led_mode_gen (
        .clk       (clk),
        .reset     (reset),
        .ctrl_reg  (ctrl_reg_q),
        .ctrl_valid(ctrl_valid_q),
        .cnt       (cnt_q),
        .pwm_cnt   (pwm_cnt_q),
        .led       (led)
    );

endmodule
